// File: rtl/cal_draw_pkg.sv
// Shared colour codes and glyph geometry for the calendar grid renderer.
package cal_draw_pkg;

    typedef logic [2:0] color_t;

    localparam color_t BG      = 3'd0;
    localparam color_t FRAME   = 3'd1;
    localparam color_t TEXT    = 3'd2;
    localparam color_t CUR_DAY = 3'd3;
    localparam color_t ALARM   = 3'd4;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

endpackage

// File: rtl/digit_glyph_rom.sv
// 8x16 digit glyphs (0-9) in a seven-segment style, one registered row per read.
module digit_glyph_rom
    import cal_draw_pkg::*;
(
    input  logic               clk,
    input  logic [3:0]         digit,
    input  logic [3:0]         row,
    output logic [GLYPH_W-1:0] bits
);

    // Segment set {a,b,c,d,e,f,g}; codes above 9 render blank
    function automatic logic [6:0] segs(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    logic [6:0]         s;
    logic [GLYPH_W-1:0] row_bits;

    // Bit 7 is the leftmost glyph column
    always_comb begin
        s        = segs(digit);
        row_bits = '0;
        case (row)
            4'd2:                       row_bits = s[6] ? 8'h7E : 8'h00;
            4'd3, 4'd4, 4'd5, 4'd6:     row_bits = {1'b0, s[1], 4'b0000, s[5], 1'b0};
            4'd7:                       row_bits = s[0] ? 8'h7E : 8'h00;
            4'd8, 4'd9, 4'd10, 4'd11,
            4'd12:                      row_bits = {1'b0, s[2], 4'b0000, s[4], 1'b0};
            4'd13:                      row_bits = s[3] ? 8'h7E : 8'h00;
            default:                    row_bits = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        bits <= row_bits;
    end

endmodule

// File: rtl/cal_grid_draw.sv
// Month calendar grid overlay: 3-stage pixel pipeline with per-frame shadowed settings.
module cal_grid_draw
    import cal_draw_pkg::*;
#(
    parameter int COLS         = 7,
    parameter int ROWS         = 6,
    parameter int CELL_W_LOG2  = 5,
    parameter int CELL_H_LOG2  = 5,
    parameter int GRID_X0      = 40,
    parameter int GRID_Y0      = 160,
    parameter int PIX_X_W      = 12,
    parameter int PIX_Y_W      = 12,
    parameter int BLINK_FRAMES = 30,
    parameter int DIG_X0       = 8,
    parameter int DIG_Y0       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pix_valid_i,
    input  logic               frame_start_i,
    input  logic [PIX_X_W-1:0] pos_x_i,
    input  logic [PIX_Y_W-1:0] pos_y_i,
    input  logic [2:0]         first_wday_i,
    input  logic [4:0]         days_in_month_i,
    input  logic [4:0]         cur_day_i,
    input  logic [31:0]        alarm_mask_i,
    output color_t             pix_color_o,
    output logic               pix_valid_o,
    output logic               in_grid_o
);

    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GRID_X1 = GRID_X0 + (COLS << CELL_W_LOG2);
    localparam int GRID_Y1 = GRID_Y0 + (ROWS << CELL_H_LOG2);
    localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (BLINK_FRAMES > 0) ? CNT_W'(BLINK_FRAMES - 1) : '0;
    localparam logic [CELL_H_LOG2-1:0] ALARM_ROW = CELL_H_LOG2'((1 << CELL_H_LOG2) - 2);

    logic [2:0]       sh_fw;
    logic [4:0]       sh_dim, sh_cur;
    logic [31:0]      sh_alarm;
    logic             sh_blink;
    logic [CNT_W-1:0] frame_cnt;
    logic             blink_on;

    // sh_blink takes the pre-toggle phase so a frame's blink state is fixed at its start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_fw     <= '0;
            sh_dim    <= 5'd31;
            sh_cur    <= '0;
            sh_alarm  <= '0;
            sh_blink  <= 1'b1;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start_i) begin
            sh_fw    <= (first_wday_i > 3'd6) ? 3'd0 : first_wday_i;
            sh_dim   <= (days_in_month_i < 5'd28) ? 5'd28 : days_in_month_i;
            sh_cur   <= cur_day_i;
            sh_alarm <= alarm_mask_i;
            sh_blink <= blink_on;
            if (BLINK_FRAMES == 0) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    logic [31:0] px, py, dx, dy;
    logic        in_grid;

    assign px      = 32'(pos_x_i);
    assign py      = 32'(pos_y_i);
    assign dx      = px - 32'(GRID_X0);
    assign dy      = py - 32'(GRID_Y0);
    assign in_grid = (px >= GRID_X0) && (px < GRID_X1) && (py >= GRID_Y0) && (py < GRID_Y1);

    logic                   s1_valid, s1_in_grid;
    logic [COL_W-1:0]       s1_col;
    logic [ROW_W-1:0]       s1_row;
    logic [CELL_W_LOG2-1:0] s1_xoff;
    logic [CELL_H_LOG2-1:0] s1_yoff;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid   <= 1'b0;
            s1_in_grid <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            s1_xoff    <= '0;
            s1_yoff    <= '0;
        end else begin
            s1_valid   <= pix_valid_i;
            s1_in_grid <= in_grid;
            s1_col     <= COL_W'(dx >> CELL_W_LOG2);
            s1_row     <= ROW_W'(dy >> CELL_H_LOG2);
            s1_xoff    <= CELL_W_LOG2'(dx);
            s1_yoff    <= CELL_H_LOG2'(dy);
        end
    end

    logic [7:0]  idx, day;
    logic [3:0]  tens, ones, rom_digit, rom_row;
    logic [2:0]  gcol;
    logic [31:0] xo, yo;
    logic        day_valid, dig_y, in_tens, in_ones, glyph_en, is_alarm, is_cur, on_frame;

    always_comb begin
        idx       = 8'(s1_row) * 8'(COLS) + 8'(s1_col);
        day       = idx + 8'd1 - 8'(sh_fw);
        day_valid = (idx >= 8'(sh_fw)) && (day <= 8'(sh_dim));
        tens      = (day >= 8'd30) ? 4'd3 : (day >= 8'd20) ? 4'd2 : (day >= 8'd10) ? 4'd1 : 4'd0;
        ones      = 4'(day - 8'(tens) * 8'd10);
        xo        = 32'(s1_xoff);
        yo        = 32'(s1_yoff);
        dig_y     = (yo >= DIG_Y0) && (yo < DIG_Y0 + GLYPH_H);
        in_tens   = (xo >= DIG_X0) && (xo < DIG_X0 + GLYPH_W);
        in_ones   = (xo >= DIG_X0 + GLYPH_W) && (xo < DIG_X0 + 2 * GLYPH_W);
        glyph_en  = dig_y && day_valid && (in_ones || (in_tens && tens != 4'd0));
        rom_digit = in_tens ? tens : ones;
        rom_row   = 4'(yo - DIG_Y0);
        gcol      = in_tens ? 3'(xo - DIG_X0) : 3'(xo - DIG_X0 - GLYPH_W);
        is_alarm  = day_valid && sh_alarm[day[4:0]] && (s1_yoff == ALARM_ROW);
        is_cur    = day_valid && (day == 8'(sh_cur)) && sh_blink;
        on_frame  = (s1_xoff == '0) || (s1_yoff == '0);
    end

    logic [GLYPH_W-1:0] glyph_bits;

    digit_glyph_rom u_rom (
        .clk   (clk_i),
        .digit (rom_digit),
        .row   (rom_row),
        .bits  (glyph_bits)
    );

    logic       s2_valid, s2_in_grid, s2_frame, s2_day_valid, s2_glyph_en, s2_alarm, s2_cur;
    logic [2:0] s2_gcol;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid     <= 1'b0;
            s2_in_grid   <= 1'b0;
            s2_frame     <= 1'b0;
            s2_day_valid <= 1'b0;
            s2_glyph_en  <= 1'b0;
            s2_alarm     <= 1'b0;
            s2_cur       <= 1'b0;
            s2_gcol      <= '0;
        end else begin
            s2_valid     <= s1_valid;
            s2_in_grid   <= s1_in_grid;
            s2_frame     <= on_frame;
            s2_day_valid <= day_valid;
            s2_glyph_en  <= glyph_en;
            s2_alarm     <= is_alarm;
            s2_cur       <= is_cur;
            s2_gcol      <= gcol;
        end
    end

    color_t color;

    always_comb begin
        color = BG;
        if (!s2_in_grid)                                color = BG;
        else if (s2_frame)                              color = FRAME;
        else if (!s2_day_valid)                         color = BG;
        else if (s2_glyph_en && glyph_bits[3'd7 - s2_gcol]) color = TEXT;
        else if (s2_alarm)                              color = ALARM;
        else if (s2_cur)                                color = CUR_DAY;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pix_color_o <= BG;
            pix_valid_o <= 1'b0;
            in_grid_o   <= 1'b0;
        end else begin
            pix_color_o <= s2_valid ? color : BG;
            pix_valid_o <= s2_valid;
            in_grid_o   <= s2_valid && s2_in_grid;
        end
    end

endmodule

// File: doc/cal_grid_draw.md
CAL_GRID_DRAW -- requirements
Module: cal_grid_draw

Interface
REQ-001 Parameters SHALL be (name, default, meaning): COLS 7 grid columns; ROWS 6 grid rows; CELL_W_LOG2 5 cell width 2^n px; CELL_H_LOG2 5 cell height 2^n px; GRID_X0 40 grid left px; GRID_Y0 160 grid top px; PIX_X_W 12 x width; PIX_Y_W 12 y width; BLINK_FRAMES 30 frames per blink phase (0 = no blink); DIG_X0 8 first digit x offset in cell; DIG_Y0 8 digit y offset in cell.
REQ-002 Ports SHALL be (name direction width meaning): clk_i in 1 pixel clock; rst_i in 1 async active-high reset; pix_valid_i in 1 pixel qualifier; frame_start_i in 1 one-cycle frame-start pulse; pos_x_i in PIX_X_W pixel x; pos_y_i in PIX_Y_W pixel y; first_wday_i in 3 weekday of day 1 (0=Mon); days_in_month_i in 5 month length; cur_day_i in 5 current day; alarm_mask_i in 32 bit d = alarm on day d; pix_color_o out 3 colour; pix_valid_o out 1 output qualifier; in_grid_o out 1 pixel inside grid.
REQ-003 The block SHALL use one clock, clk_i; rst_i SHALL be asynchronous and active-high.

Function
REQ-004 Latency pos_*_i/pix_valid_i -> pix_color_o/pix_valid_o/in_grid_o SHALL be exactly 3 cycles, one pixel per cycle, no stalls.
REQ-005 first_wday_i, days_in_month_i, cur_day_i, alarm_mask_i SHALL be captured into shadow registers only on cycles with frame_start_i=1; changes mid-frame SHALL NOT be visible until next frame.
REQ-006 Shadow capture SHALL clamp: first_wday>6 -> 0; days_in_month<28 -> 28, >31 -> 31.
REQ-007 Stage 1: in_grid = GRID_X0 <= x < GRID_X0+COLS*2^CELL_W_LOG2 and same for y/ROWS; col/row = offset >> LOG2; cell offsets = low bits.
REQ-008 Stage 2: idx = row*COLS+col; day = idx - first_wday + 1 (signed, 6 bits); day_valid = 1 <= day <= days_in_month; tens/ones digits of day; glyph ROM address formed for 8x16 glyph.
REQ-009 Stage 3: glyph ROM synchronous read; colour selected by priority: outside grid -> BG; cell offset x==0 or y==0 -> FRAME; !day_valid -> BG; glyph pixel set -> TEXT; alarm day and cell y offset == 2^CELL_H_LOG2-2 -> ALARM; current day and blink_on -> CUR_DAY; else BG.
REQ-010 Tens digit SHALL be blank for days 1-9; ones digit at DIG_X0+8.
REQ-011 cur_day 0 or > days_in_month SHALL highlight no cell; alarm bit 0 and bits above days_in_month SHALL be ignored.
REQ-012 Frame counter SHALL increment on frame_start_i; on reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_on; BLINK_FRAMES=0 SHALL force blink_on=1.
REQ-013 pix_valid_i=0 pixels SHALL propagate with pix_valid_o=0 and pix_color_o=BG.
REQ-014 frame_start_i coincident with a pixel SHALL apply new shadow values to that pixel's stage-2 computation onward only from the following cycle.

Reset
REQ-015 On rst_i: pix_color_o=BG, pix_valid_o=0, in_grid_o=0, all pipeline valids 0, frame counter 0, blink_on=1, shadows first_wday 0, days 31, cur_day 0, alarm mask 0.
REQ-016 Reset asserted mid-frame SHALL flush the pipeline; output resumes 3 cycles after deassertion.

Structure
REQ-017 Package cal_draw_pkg SHALL hold colour typedef (3-bit), BG/FRAME/TEXT/CUR_DAY/ALARM colour constants, glyph width/height constants.
REQ-018 Glyph storage SHALL be sub-module digit_glyph_rom (10 digits x 16 rows x 8 bits, 1-cycle registered read).

Verification
REQ-019 first_wday=2, days=30, frame_start, pixel at cell row0 col2 digit pixel -> day 1 glyph TEXT after 3 cycles; row0 col1 -> BG.
REQ-020 days_in_month 28 vs 31 toggled mid-frame -> cell day 29 blank until next frame_start, then drawn.
REQ-021 cur_day=15, BLINK_FRAMES=2 -> day-15 background CUR_DAY in frames 0-1, BG in frames 2-3, CUR_DAY frames 4-5.
REQ-022 alarm_mask=32'h0000_0402 -> underline ALARM on days 1 and 10 only; bit 0 ignored.
REQ-023 first_wday=7, days=3 at capture -> treated as 0 and 28.
REQ-024 rst_i asserted with pipeline full -> outputs BG/0 immediately; first valid output 3 cycles after release.
